// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, accumulator sizing and output-narrowing helpers for the FIR MAC core.
package fir_pkg;
  typedef enum logic [1:0] {FIR_IDLE, FIR_MAC, FIR_OUT} fir_state_e;
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic signed [63:0] trunc(input logic signed [63:0] v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: TAPS-deep sample shift register, x[0] newest, with an indexed read port.
module fir_delay_line #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      shift_i,
  input  logic signed [DATA_W-1:0]  din_i,
  input  logic [$clog2(TAPS)-1:0]   idx_i,
  output logic signed [DATA_W-1:0]  dout_o
);
  logic signed [DATA_W-1:0] x_q [TAPS];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) x_q <= '{default: '0};
    else if (shift_i) begin
      x_q[0] <= din_i;
      for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
    end
  assign dout_o = x_q[idx_i];
endmodule

// File: rtl/fir_mac_core.sv
// fir_mac_core: single-multiplier sequential FIR, one MAC per tap per sample, valid/ready output.
// Define FIR_SAT_EN to clamp the scaled result to DATA_W instead of wrapping.
module fir_mac_core
  import fir_pkg::*;
#(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int SHIFT  = 15
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DATA_W-1:0]  s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [DATA_W-1:0]  m_data,
  output logic                      busy
);
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
  fir_state_e state_q;
  logic [AW:0] cnt_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sh;
  logic signed [COEF_W-1:0] coef_q [TAPS], coef_d [TAPS], snap_q [TAPS];
  logic signed [DATA_W-1:0] x_rd, m_data_q, m_data_d;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic m_valid_q;
  assign s_ready = state_q == FIR_IDLE;
  assign busy    = !s_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  // A write landing in the accept cycle must be visible to the snapshot.
  for (genvar i = 0; i < TAPS; i++)
    assign coef_d[i] = (coef_we && coef_addr == AW'(i)) ? coef_wdata : coef_q[i];
  fir_delay_line #(.TAPS(TAPS), .DATA_W(DATA_W)) u_dl (
    .clk_i(ACLK), .rst_i(ARESET), .shift_i(s_valid && s_ready),
    .din_i(s_data), .idx_i(cnt_q[AW-1:0]), .dout_o(x_rd)
  );
  assign prod   = snap_q[cnt_q[AW-1:0]] * x_rd;
  assign acc_d  = acc_q + ACC_W'(prod);
  assign acc_sh = acc_q >>> SHIFT;
`ifdef FIR_SAT_EN
  assign m_data_d = DATA_W'(sat(64'(acc_sh), DATA_W));
`else
  assign m_data_d = DATA_W'(trunc(64'(acc_sh), DATA_W));
`endif
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) coef_q <= '{default: '0};
    else coef_q <= coef_d;
  // cnt_q MSB set means all TAPS products are in; TAPS is a power of two.
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state_q   <= FIR_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      snap_q    <= '{default: '0};
    end else
      case (state_q)
        FIR_IDLE: if (s_valid) begin
          state_q <= FIR_MAC;
          cnt_q   <= '0;
          acc_q   <= '0;
          snap_q  <= coef_d;
        end
        FIR_MAC: if (cnt_q[AW]) begin
          m_data_q  <= m_data_d;
          m_valid_q <= 1'b1;
          state_q   <= FIR_OUT;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
        end
        FIR_OUT: if (m_ready) begin
          m_valid_q <= 1'b0;
          state_q   <= FIR_IDLE;
        end
        default: state_q <= FIR_IDLE;
      endcase
endmodule
